// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor: valid/tag/target/2-bit counter table with decode-stage training.
// Define BRANCH_PREDICTOR_STATS_EN to build the branch and mispredict counters.
module branch_predictor #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] f_pc,
  output logic        f_pred_taken,
  output logic [31:0] f_pred_target,
  input  logic        d_valid,
  input  logic        d_is_branch,
  input  logic        d_stall,
  input  logic [31:0] d_pc,
  input  logic        d_pred_taken,
  input  logic [31:0] d_pred_target,
  input  logic        d_actual_taken,
  input  logic [31:0] d_actual_target,
  output logic        d_mispredict,
  output logic [31:0] d_redirect_pc,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = 30 - INDEX_BITS;

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tags    [ENTRIES];
  logic [31:0]        targets [ENTRIES];
  logic [1:0]         ctrs    [ENTRIES];

  logic [INDEX_BITS-1:0] f_idx;
  logic [INDEX_BITS-1:0] d_idx;
  logic [TAG_W-1:0]      f_tag;
  logic [TAG_W-1:0]      d_tag;
  logic                  d_hit;
  logic                  upd;
  logic [1:0]            ctr_next;
  logic [31:0]           pc_seq;
  logic                  dir_mis;
  logic                  tgt_mis;
  logic                  unused;

  assign unused = ^{f_pc[1:0], d_pc[1:0]};

  assign f_idx = f_pc[INDEX_BITS+1:2];
  assign f_tag = f_pc[31:INDEX_BITS+2];
  assign d_idx = d_pc[INDEX_BITS+1:2];
  assign d_tag = d_pc[31:INDEX_BITS+2];

  // Lookup reads registered state only, so a same-index update is not bypassed.
  always_comb begin
    f_pred_taken  = 1'b0;
    f_pred_target = targets[f_idx];
    if (!rst && valid[f_idx] && tags[f_idx] == f_tag) begin
      f_pred_taken = ctrs[f_idx][1];
    end
  end

  assign upd   = d_valid & d_is_branch & ~d_stall & ~rst;
  assign d_hit = valid[d_idx] & (tags[d_idx] == d_tag);

  always_comb begin
    ctr_next = ctrs[d_idx];
    if (d_actual_taken) begin
      if (ctrs[d_idx] != 2'b11) ctr_next = ctrs[d_idx] + 2'b01;
    end else begin
      if (ctrs[d_idx] != 2'b00) ctr_next = ctrs[d_idx] - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tags[i]    <= '0;
        targets[i] <= '0;
        ctrs[i]    <= 2'b01;
      end
    end else if (upd) begin
      if (d_hit) begin
        ctrs[d_idx] <= ctr_next;
        if (d_actual_taken) targets[d_idx] <= d_actual_target;
      end else begin
        valid[d_idx]   <= 1'b1;
        tags[d_idx]    <= d_tag;
        targets[d_idx] <= d_actual_target;
        ctrs[d_idx]    <= d_actual_taken ? 2'b10 : 2'b01;
      end
    end
  end

  // Sequential fallback skips the delay slot.
  assign pc_seq  = d_pc + 32'd8;
  assign dir_mis = d_pred_taken ^ d_actual_taken;
  assign tgt_mis = d_pred_taken & d_actual_taken &
                   (d_pred_target != d_actual_target);

  assign d_mispredict  = upd & (dir_mis | tgt_mis);
  assign d_redirect_pc = (d_mispredict & d_actual_taken) ?
                         d_actual_target : pc_seq;

`ifdef BRANCH_PREDICTOR_STATS_EN
  logic [31:0] br_cnt;
  logic [31:0] mp_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt <= '0;
      mp_cnt <= '0;
    end else begin
      if (upd)          br_cnt <= br_cnt + 32'd1;
      if (d_mispredict) mp_cnt <= mp_cnt + 32'd1;
    end
  end

  assign stat_branches    = br_cnt;
  assign stat_mispredicts = mp_cnt;
`else
  assign stat_branches    = 32'd0;
  assign stat_mispredicts = 32'd0;
`endif

endmodule
